// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the display encoder and the readback decoder.
//   SEG_A..SEG_G    bit positions of segments a..g inside a 7-bit pattern {g,f,e,d,c,b,a}
//   SEG7_HEX        active-high lit pattern for each hex nibble 0..F
//   SEG7_BLANK      all segments dark
//   seg7_decode()   lit pattern -> {err, blank, nibble}
//   seg7_encode()   nibble -> lit pattern (same table, so both directions always agree)
package seg7_pkg;

  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam int unsigned SEG_COUNT = SEG_G + 1;

  // Index 0 is listed last: entry n is the pattern for nibble n.
  localparam logic [15:0][SEG_COUNT-1:0] SEG7_HEX = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [SEG_COUNT-1:0] SEG7_BLANK = '0;

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] nibble;
  } seg7_dec_t;

  typedef enum logic [0:0] {
    StIdle,
    StSettle
  } seg7_cap_state_e;

  function automatic seg7_dec_t seg7_decode(input logic [SEG_COUNT-1:0] lit);
    seg7_dec_t res;
    res = '0;
    if (lit == SEG7_BLANK) begin
      res.blank = 1'b1;
    end else begin
      res.err = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (lit == SEG7_HEX[i]) begin
          res.err    = 1'b0;
          res.nibble = 4'(i);
        end
      end
    end
    return res;
  endfunction

  function automatic logic [SEG_COUNT-1:0] seg7_encode(input logic [3:0] nibble);
    return SEG7_HEX[nibble];
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-high seven-segment pattern.
//   lit_i     pattern {g,f,e,d,c,b,a}, 1 = segment lit
//   nibble_o  decoded hex value (0 when blank or illegal)
//   blank_o   all segments dark
//   err_o     pattern is neither blank nor one of the 16 hex glyphs
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [SEG_COUNT-1:0] lit_i,
  output logic [3:0]           nibble_o,
  output logic                 blank_o,
  output logic                 err_o
);

  seg7_dec_t dec;

  assign dec      = seg7_decode(lit_i);
  assign nibble_o = dec.nibble;
  assign blank_o  = dec.blank;
  assign err_o    = dec.err;

endmodule

// File: rtl/seg7_frame_capture.sv
// Receive side of the 4-digit seven-segment bus: synchronizes the 28 segment lines, waits for the
// pattern to settle, decodes each digit back to a nibble and publishes every new stable frame over
// a valid/ready handshake.
//   clk          rising-edge clock
//   reset        synchronous, active-low
//   seg_in       [6:0]=D1 a..g, [13:7]=D2, [20:14]=D3, [27:21]=D4
//   out_value    D1->[15:12] .. D4->[3:0]
//   out_blank    per digit, bit3=D1 .. bit0=D4: digit dark
//   out_err      per digit: illegal pattern
//   out_valid    frame pending; out_ready accepts it
//   overrun      sticky: a pending frame was replaced before acceptance; ovr_clear clears it
//   frame_count  frames published since reset (wrapping)
module seg7_frame_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [27:0]      seg_in,
  output logic [15:0]      out_value,
  output logic [3:0]       out_blank,
  output logic [3:0]       out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  input  logic             ovr_clear,
  output logic [CNT_W-1:0] frame_count
);

  localparam int unsigned NumDigits = 4;
  localparam int unsigned PatW      = NumDigits * SEG_COUNT;
  localparam int unsigned StCntW    = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [StCntW-1:0] StLast = StCntW'(STABLE_CYCLES - 1);

  // Input synchronizer
  logic [SYNC_STAGES-1:0][PatW-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= seg_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Normalized pattern: 1 = segment lit, whatever the bus polarity.
  logic [PatW-1:0] pat;
  assign pat = (SEG_ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];

  // Per-digit decode of the current pattern
  logic [3:0] dig_nibble [NumDigits];
  logic       dig_blank  [NumDigits];
  logic       dig_err    [NumDigits];

  for (genvar g = 0; g < NumDigits; g++) begin : gen_digit
    seg7_digit_decode u_digit_decode (
      .lit_i    (pat[g*SEG_COUNT +: SEG_COUNT]),
      .nibble_o (dig_nibble[g]),
      .blank_o  (dig_blank[g]),
      .err_o    (dig_err[g])
    );
  end

  // D1 (digit 0 on the bus) lands in the most significant nibble / flag bit.
  logic [15:0] dec_value;
  logic [3:0]  dec_blank;
  logic [3:0]  dec_err;

  always_comb begin
    dec_value = '0;
    dec_blank = '0;
    dec_err   = '0;
    for (int i = 0; i < NumDigits; i++) begin
      dec_value[15-4*i -: 4] = dig_nibble[i];
      dec_blank[3-i]         = dig_blank[i];
      dec_err[3-i]           = dig_err[i];
    end
  end

  // Settle filter
  seg7_cap_state_e state_q, state_d;
  logic [StCntW-1:0] cnt_q, cnt_d;
  logic [PatW-1:0]   prev_q;
  logic [PatW-1:0]   last_q;
  logic              publish;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    publish = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pat != last_q) begin
          state_d = StSettle;
          cnt_d   = '0;
          // With a one-cycle filter the change itself is already long enough.
          if (cnt_d == StLast) begin
            state_d = StIdle;
            publish = 1'b1;
          end
        end
      end
      StSettle: begin
        if (pat != prev_q) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + StCntW'(1);
        end
        if (cnt_d == StLast) begin
          state_d = StIdle;
          // A bus that bounced back to the published frame is not a new frame.
          publish = (pat != last_q);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= pat;
    end
  end

  // Output frame and handshake
  logic             accept;
  logic             ovr_set;
  logic [15:0]      value_d;
  logic [3:0]       blank_d;
  logic [3:0]       err_d;
  logic             valid_d;
  logic             overrun_d;
  logic [CNT_W-1:0] count_d;
  logic [PatW-1:0]  last_d;

  assign accept  = out_valid && out_ready;
  assign ovr_set = publish && out_valid && !out_ready;

  always_comb begin
    value_d   = out_value;
    blank_d   = out_blank;
    err_d     = out_err;
    valid_d   = out_valid;
    count_d   = frame_count;
    last_d    = last_q;
    overrun_d = overrun;
    if (publish) begin
      value_d = dec_value;
      blank_d = dec_blank;
      err_d   = dec_err;
      valid_d = 1'b1;
      count_d = frame_count + CNT_W'(1);
      last_d  = pat;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    // Set has priority over a simultaneous clear.
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (ovr_clear) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_value   <= '0;
      out_blank   <= '0;
      out_err     <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      frame_count <= '0;
      last_q      <= '0;  // all dark, so an idle dark bus never publishes
    end else begin
      out_value   <= value_d;
      out_blank   <= blank_d;
      out_err     <= err_d;
      out_valid   <= valid_d;
      overrun     <= overrun_d;
      frame_count <= count_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_seg7_frame_capture.sv
module tb_seg7_frame_capture;

  logic        clk;
  logic        reset;
  logic [27:0] seg_in;
  logic [15:0] out_value;
  logic [3:0]  out_blank;
  logic [3:0]  out_err;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;
  logic        ovr_clear;
  logic [15:0] frame_count;

  // Narrow-counter instance for the wrap check
  logic [15:0] w_value;
  logic [3:0]  w_blank;
  logic [3:0]  w_err;
  logic        w_valid;
  logic        w_overrun;
  logic [1:0]  w_count;

  seg7_frame_capture dut (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .out_value   (out_value),
    .out_blank   (out_blank),
    .out_err     (out_err),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .ovr_clear   (ovr_clear),
    .frame_count (frame_count)
  );

  seg7_frame_capture #(.CNT_W(2)) dut_w (
    .clk         (clk),
    .reset       (reset),
    .seg_in      (seg_in),
    .out_value   (w_value),
    .out_blank   (w_blank),
    .out_err     (w_err),
    .out_valid   (w_valid),
    .out_ready   (out_ready),
    .overrun     (w_overrun),
    .ovr_clear   (ovr_clear),
    .frame_count (w_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic [15:0] count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  localparam logic [6:0] DARK = 7'h00;

  // Hand-typed active-high glyphs
  function automatic logic [6:0] lit(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Active-low bus from D1..D4 lit patterns
  function automatic logic [27:0] bus(input logic [6:0] d1, input logic [6:0] d2,
                                      input logic [6:0] d3, input logic [6:0] d4);
    return ~{d4, d3, d2, d1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clocks until frame_count moves away from its current value; -1 on timeout.
  task automatic wait_publish(output int lat);
    logic [15:0] start;
    start = frame_count;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      if (frame_count !== start) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  // Monitor: every newly presented frame is popped and compared.
  initial begin
    logic        prev_valid;
    logic [15:0] prev_cnt;
    exp_t        e;
    prev_valid = 1'b0;
    prev_cnt   = '0;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && (prev_valid !== 1'b1 || frame_count !== prev_cnt)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", {16'h0, out_value}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("frame_value", {16'h0, out_value}, {16'h0, e.value});
          check("frame_blank", {28'h0, out_blank}, {28'h0, e.blank});
          check("frame_err", {28'h0, out_err}, {28'h0, e.err});
          check("frame_count", {16'h0, frame_count}, {16'h0, e.count});
        end
      end
      prev_valid = out_valid;
      prev_cnt   = frame_count;
    end
  end

  initial begin
    int lat;
    reset     = 1'b0;
    out_ready = 1'b0;
    ovr_clear = 1'b0;
    seg_in    = '0;

    // 1: reset with a random bus, then an all-dark bus never publishes
    for (int i = 0; i < 3; i++) begin
      seg_in = 28'($urandom());
      tick(1);
    end
    check("rst_value", {16'h0, out_value}, 32'h0);
    check("rst_blank", {28'h0, out_blank}, 32'h0);
    check("rst_err", {28'h0, out_err}, 32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_count", {16'h0, frame_count}, 32'h0);
    seg_in = 28'hFFF_FFFF;
    tick(1);
    reset = 1'b1;
    tick(20);
    check("dark_no_valid", {31'h0, out_valid}, 32'h0);

    // 2: latency
    exp_q.push_back('{16'h1234, 4'h0, 4'h0, 16'd1});
    seg_in = bus(lit(4'h1), lit(4'h2), lit(4'h3), lit(4'h4));
    wait_publish(lat);
    check("lat_1234", 32'(lat), 32'd6);
    pulse_ready();
    check("valid_drop_1234", {31'h0, out_valid}, 32'h0);

    // 3: D3 bouncing between '3' and '8', then '8' held
    for (int i = 0; i < 10; i++) begin
      seg_in = bus(lit(4'h1), lit(4'h2), (i % 2 == 0) ? lit(4'h8) : lit(4'h3), lit(4'h4));
      tick(2);
    end
    exp_q.push_back('{16'h1284, 4'h0, 4'h0, 16'd2});
    seg_in = bus(lit(4'h1), lit(4'h2), lit(4'h8), lit(4'h4));
    wait_publish(lat);
    check("lat_bounce", 32'(lat), 32'd6);

    // 4: 1284 still pending, 5678 overwrites it
    exp_q.push_back('{16'h5678, 4'h0, 4'h0, 16'd3});
    seg_in = bus(lit(4'h5), lit(4'h6), lit(4'h7), lit(4'h8));
    wait_publish(lat);
    check("lat_overwrite", 32'(lat), 32'd6);
    check("overrun_set", {31'h0, overrun}, 32'h1);
    check("valid_kept", {31'h0, out_valid}, 32'h1);
    ovr_clear = 1'b1;
    tick(1);
    ovr_clear = 1'b0;
    check("overrun_cleared", {31'h0, overrun}, 32'h0);
    pulse_ready();
    check("valid_drop_5678", {31'h0, out_valid}, 32'h0);

    // 5: dark, illegal, 'A', 'F'
    exp_q.push_back('{16'h00AF, 4'b1000, 4'b0100, 16'd4});
    seg_in = bus(DARK, 7'h49, lit(4'hA), lit(4'hF));
    wait_publish(lat);
    check("lat_decode", 32'(lat), 32'd6);

    // Overrun set while ovr_clear is held: set wins, then the clear takes effect
    ovr_clear = 1'b1;
    exp_q.push_back('{16'h9ABC, 4'h0, 4'h0, 16'd5});
    seg_in = bus(lit(4'h9), lit(4'hA), lit(4'hB), lit(4'hC));
    wait_publish(lat);
    check("lat_set_wins", 32'(lat), 32'd6);
    check("overrun_set_wins", {31'h0, overrun}, 32'h1);
    tick(1);
    check("overrun_late_clear", {31'h0, overrun}, 32'h0);
    ovr_clear = 1'b0;

    // 6: five publishes on a 2-bit counter wrap to 1
    check("wrap_count", {30'h0, w_count}, 32'd1);
    pulse_ready();
    check("valid_drop_9abc", {31'h0, out_valid}, 32'h0);

    // Reset in the middle of settling drops the frame
    seg_in = bus(lit(4'h1), lit(4'h1), lit(4'h1), lit(4'h1));
    tick(4);
    reset  = 1'b0;
    seg_in = 28'hFFF_FFFF;
    tick(2);
    reset = 1'b1;
    tick(20);
    check("midrst_valid", {31'h0, out_valid}, 32'h0);
    check("midrst_count", {16'h0, frame_count}, 32'h0);

    tick(2);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
